ir_gree_rx: RTL and testbench

// - Decodes demodulated IR from an off-board receiver module. Inverse of our 38 kHz AC-remote transmitter.
// - Frame: leader (9000us mark, 4500us space), then 35 data bits, then a connect code (750us mark, 20000us space),

---
 rtl/ir_gree_rx_pkg.sv | 49 ++++
 rtl/ir_rx_sync.sv | 56 +++++
 rtl/ir_gree_rx.sv | 178 +++++++++++++++++
 tb/tb_ir_gree_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_gree_rx_pkg.sv
// Shared timing for the GREE-style IR link: nominal transmitter timings,
// receiver acceptance windows, bit counts and the receiver state encoding.
package ir_gree_rx_pkg;

   localparam int DUR_W          = 15;
   localparam int TIMEOUT_US_DEF = 25000;
   localparam int NBITS_D35      = 35;
   localparam int NBITS_D32      = 32;

   // Nominal timings the transmitter produces (us)
   localparam int T_LEAD_M_US = 9000;
   localparam int T_LEAD_S_US = 4500;
   localparam int T_MARK_US   = 750;
   localparam int T_SPACE0_US = 450;
   localparam int T_SPACE1_US = 1500;
   localparam int T_CONN_S_US = 20000;

   // Inclusive acceptance windows (us)
   localparam int LEAD_M_MIN = 8000;
   localparam int LEAD_M_MAX = 10000;
   localparam int LEAD_S_MIN = 4000;
   localparam int LEAD_S_MAX = 5000;
   localparam int MARK_MIN   = 500;
   localparam int MARK_MAX   = 1000;
   localparam int SP0_MIN    = 300;
   localparam int SP0_MAX    = 700;
   localparam int SP1_MIN    = 1200;
   localparam int SP1_MAX    = 1800;
   localparam int CONN_S_MIN = 18000;
   localparam int CONN_S_MAX = 22000;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LEAD_M = 4'd1,
      ST_LEAD_S = 4'd2,
      ST_D35_M  = 4'd3,
      ST_D35_S  = 4'd4,
      ST_CONN_M = 4'd5,
      ST_CONN_S = 4'd6,
      ST_D32_M  = 4'd7,
      ST_D32_S  = 4'd8,
      ST_PAD_M  = 4'd9
   } rx_state_e;

   function automatic logic in_win(input logic [DUR_W-1:0] dur, input int lo, input int hi);
      return (int'(dur) >= lo) && (int'(dur) <= hi);
   endfunction

endpackage

// File: rtl/ir_rx_sync.sv
// Input conditioning for the IR receiver: 2-FF synchronizer, registered
// fall/rise strobes and a prescaler producing a 1us tick.
module ir_rx_sync #(
   parameter int CLK_MHZ = 125
) (
   input  logic clk,
   input  logic rst,
   input  logic ir_rx_n,
   output logic fall,
   output logic rise,
   output logic tick
);

   localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_MHZ - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          sync3_q, sync3_d;
   logic          fall_q, fall_d;
   logic          rise_q, rise_d;
   logic [PW-1:0] pre_q, pre_d;

   assign tick = (pre_q == PRE_LAST);
   assign fall = fall_q;
   assign rise = rise_q;

   always_comb begin
      sync1_d = ir_rx_n;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      fall_d  = ~sync2_q & sync3_q;
      rise_d  = sync2_q & ~sync3_q;
      pre_d   = tick ? '0 : pre_q + PW'(1);
   end

   // Synchronizer resets to the idle (space) level so no false edge follows reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
         fall_q  <= 1'b0;
         rise_q  <= 1'b0;
         pre_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         fall_q  <= fall_d;
         rise_q  <= rise_d;
         pre_q   <= pre_d;
      end
   end

endmodule

// File: rtl/ir_gree_rx.sv
// GREE-style IR frame receiver: measures mark/space durations, decodes the
// 35-bit and 32-bit payloads and presents them split like the transmitter inputs.
module ir_gree_rx
   import ir_gree_rx_pkg::*;
#(
   parameter int CLK_MHZ    = 125,
   parameter int TIMEOUT_US = TIMEOUT_US_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ir_rx_n,
   output logic [31:0] rx_data35_1,
   output logic [2:0]  rx_data35_0,
   output logic [31:0] rx_data32,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        busy,
   output logic        led_out
);

   localparam logic [DUR_W-1:0] TMO    = DUR_W'(TIMEOUT_US);
   localparam logic [5:0]       LAST35 = 6'(NBITS_D35 - 1);
   localparam logic [5:0]       LAST32 = 6'(NBITS_D32 - 1);

   logic fall, rise, tick;

   rx_state_e        state_q, state_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [5:0]       bitcnt_q, bitcnt_d;
   logic [34:0]      sr35_q, sr35_d;
   logic [31:0]      sr32_q, sr32_d;
   logic [31:0]      d35_1_q, d35_1_d;
   logic [2:0]       d35_0_q, d35_0_d;
   logic [31:0]      d32_q, d32_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             led_q, led_d;
   logic             fail, sp_bit, sp_ok, mark_ok;

   ir_rx_sync #(.CLK_MHZ(CLK_MHZ)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .ir_rx_n (ir_rx_n),
      .fall    (fall),
      .rise    (rise),
      .tick    (tick)
   );

   always_comb begin
      state_d  = state_q;
      dur_d    = dur_q;
      bitcnt_d = bitcnt_q;
      sr35_d   = sr35_q;
      sr32_d   = sr32_q;
      d35_1_d  = d35_1_q;
      d35_0_d  = d35_0_q;
      d32_d    = d32_q;
      led_d    = led_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      fail     = 1'b0;
      sp_bit   = in_win(dur_q, SP1_MIN, SP1_MAX);
      sp_ok    = sp_bit || in_win(dur_q, SP0_MIN, SP0_MAX);
      mark_ok  = in_win(dur_q, MARK_MIN, MARK_MAX);

      // A tick coinciding with the edge is counted so the value seen at the
      // next edge equals the elapsed whole microseconds.
      if (fall || rise) begin
         dur_d = DUR_W'(tick);
      end else if (tick && (dur_q != TMO)) begin
         dur_d = dur_q + DUR_W'(1);
      end

      if ((state_q != ST_IDLE) && (dur_q == TMO)) begin
         fail = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (fall) state_d = ST_LEAD_M;
            ST_LEAD_M: if (rise) begin
               if (in_win(dur_q, LEAD_M_MIN, LEAD_M_MAX)) state_d = ST_LEAD_S;
               else fail = 1'b1;
            end
            ST_LEAD_S: if (fall) begin
               if (in_win(dur_q, LEAD_S_MIN, LEAD_S_MAX)) begin
                  state_d  = ST_D35_M;
                  bitcnt_d = '0;
               end else fail = 1'b1;
            end
            ST_D35_M: if (rise) begin
               if (mark_ok) state_d = ST_D35_S;
               else fail = 1'b1;
            end
            ST_D35_S: if (fall) begin
               if (sp_ok) begin
                  sr35_d   = {sr35_q[33:0], sp_bit};
                  bitcnt_d = bitcnt_q + 6'd1;
                  state_d  = (bitcnt_q == LAST35) ? ST_CONN_M : ST_D35_M;
               end else fail = 1'b1;
            end
            ST_CONN_M: if (rise) begin
               if (mark_ok) state_d = ST_CONN_S;
               else fail = 1'b1;
            end
            ST_CONN_S: if (fall) begin
               if (in_win(dur_q, CONN_S_MIN, CONN_S_MAX)) begin
                  state_d  = ST_D32_M;
                  bitcnt_d = '0;
               end else fail = 1'b1;
            end
            ST_D32_M: if (rise) begin
               if (mark_ok) state_d = ST_D32_S;
               else fail = 1'b1;
            end
            ST_D32_S: if (fall) begin
               if (sp_ok) begin
                  sr32_d   = {sr32_q[30:0], sp_bit};
                  bitcnt_d = bitcnt_q + 6'd1;
                  state_d  = (bitcnt_q == LAST32) ? ST_PAD_M : ST_D32_M;
               end else fail = 1'b1;
            end
            // Pad bit value is never sampled: the frame commits at the end of its mark
            ST_PAD_M: if (rise) begin
               if (mark_ok) begin
                  d35_1_d = sr35_q[34:3];
                  d35_0_d = sr35_q[2:0];
                  d32_d   = sr32_q;
                  valid_d = 1'b1;
                  led_d   = ~led_q;
                  state_d = ST_IDLE;
               end else fail = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (fail) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         dur_q    <= '0;
         bitcnt_q <= '0;
         sr35_q   <= '0;
         sr32_q   <= '0;
         d35_1_q  <= '0;
         d35_0_q  <= '0;
         d32_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         led_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dur_q    <= dur_d;
         bitcnt_q <= bitcnt_d;
         sr35_q   <= sr35_d;
         sr32_q   <= sr32_d;
         d35_1_q  <= d35_1_d;
         d35_0_q  <= d35_0_d;
         d32_q    <= d32_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         led_q    <= led_d;
      end
   end

   assign rx_data35_1 = d35_1_q;
   assign rx_data35_0 = d35_0_q;
   assign rx_data32   = d32_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign led_out     = led_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_gree_rx.sv
// Directed bench for ir_gree_rx, run with a 1 MHz clock so one cycle is one microsecond.
`timescale 1ns/1ps
module tb_ir_gree_rx;
   import ir_gree_rx_pkg::*;

   localparam logic [34:0] NOM35  = 35'h5_A5A5_A5A5;
   localparam logic [31:0] NOM32  = 32'h1234_5678;
   localparam logic [34:0] EDGE35 = 35'h3_C3C3_C3C3;
   localparam logic [31:0] EDGE32 = 32'hFEDC_BA98;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ir_rx_n = 1'b1;
   logic [31:0] rx_data35_1;
   logic [2:0]  rx_data35_0;
   logic [31:0] rx_data32;
   logic        frame_valid, frame_err, busy, led_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int valid_cyc = 0;
   int err_cyc = 0;
   logic [31:0] cap1 = '0;
   logic [2:0]  cap0 = '0;
   logic [31:0] cap32 = '0;

   ir_gree_rx #(.CLK_MHZ(1), .TIMEOUT_US(25000)) dut (
      .clk         (clk),
      .rst         (rst),
      .ir_rx_n     (ir_rx_n),
      .rx_data35_1 (rx_data35_1),
      .rx_data35_0 (rx_data35_0),
      .rx_data32   (rx_data32),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .busy        (busy),
      .led_out     (led_out)
   );

   always #500 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid) begin
         n_valid   <= n_valid + 1;
         valid_cyc <= cyc;
         cap1      <= rx_data35_1;
         cap0      <= rx_data35_0;
         cap32     <= rx_data32;
      end
      if (frame_err) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
   end

   task automatic line(input logic lvl, input int us);
      ir_rx_n = lvl;
      #(us * 1000);
   endtask

   task automatic send_bits(input logic [34:0] v, input int n,
                            input int s0a, input int s0b, input int s1a, input int s1b);
      for (int i = n - 1; i >= 0; i--) begin
         line(1'b0, T_MARK_US);
         if (v[i]) line(1'b1, i[0] ? s1b : s1a);
         else      line(1'b1, i[0] ? s0b : s0a);
      end
   endtask

   task automatic send_frame(input logic [34:0] d35, input logic [31:0] d32, input logic pad,
                             input int s0a, input int s0b, input int s1a, input int s1b,
                             output int rc);
      line(1'b0, T_LEAD_M_US);
      line(1'b1, T_LEAD_S_US);
      send_bits(d35, 35, s0a, s0b, s1a, s1b);
      line(1'b0, T_MARK_US);
      line(1'b1, T_CONN_S_US);
      send_bits({3'b000, d32}, 32, s0a, s0b, s1a, s1b);
      line(1'b0, T_MARK_US);
      rc = cyc;
      line(1'b1, pad ? T_SPACE1_US : T_SPACE0_US);
      line(1'b1, 2000);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ir_rx_n = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #200;
      checks++; if (rx_data35_1 !== 32'h0) begin errors++; $display("FAIL reset_d35_1 got=%h exp=0", rx_data35_1); end
      checks++; if (rx_data35_0 !== 3'h0) begin errors++; $display("FAIL reset_d35_0 got=%h exp=0", rx_data35_0); end
      checks++; if (rx_data32 !== 32'h0) begin errors++; $display("FAIL reset_d32 got=%h exp=0", rx_data32); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", led_out); end
      $display("reset: outputs d35_1=%h d35_0=%h d32=%h busy=%b led=%b", rx_data35_1, rx_data35_0, rx_data32, busy, led_out);
   endtask

   task automatic test_nominal();
      int v, e, rc;
      @(negedge clk);
      v = n_valid;
      e = n_err;
      send_frame(NOM35, NOM32, 1'b0, T_SPACE0_US, T_SPACE0_US, T_SPACE1_US, T_SPACE1_US, rc);
      #200;
      checks++; if (n_valid !== v + 1) begin errors++; $display("FAIL nominal_valid_count got=%0d exp=%0d", n_valid, v + 1); end
      checks++; if (valid_cyc - rc !== 4) begin errors++; $display("FAIL nominal_latency got=%0d exp=4", valid_cyc - rc); end
      checks++; if (cap1 !== 32'hB4B4_B4B4) begin errors++; $display("FAIL nominal_d35_1 got=%h exp=b4b4b4b4", cap1); end
      checks++; if (cap0 !== 3'b101) begin errors++; $display("FAIL nominal_d35_0 got=%b exp=101", cap0); end
      checks++; if (cap32 !== 32'h1234_5678) begin errors++; $display("FAIL nominal_d32 got=%h exp=12345678", cap32); end
      checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL nominal_led got=%b exp=1", led_out); end
      checks++; if (n_err !== e) begin errors++; $display("FAIL nominal_no_err got=%0d exp=%0d", n_err, e); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy got=%b exp=0", busy); end
      $display("nominal: d35_1=%h d35_0=%b d32=%h latency=%0d led=%b", cap1, cap0, cap32, valid_cyc - rc, led_out);
   endtask

   task automatic test_window_edges();
      int v, e, rc;
      @(negedge clk);
      v = n_valid;
      e = n_err;
      send_frame(EDGE35, EDGE32, 1'b0, 300, 700, 1200, 1800, rc);
      #200;
      checks++; if (n_valid !== v + 1) begin errors++; $display("FAIL edges_valid_count got=%0d exp=%0d", n_valid, v + 1); end
      checks++; if (cap1 !== 32'h7878_7878) begin errors++; $display("FAIL edges_d35_1 got=%h exp=78787878", cap1); end
      checks++; if (cap0 !== 3'b011) begin errors++; $display("FAIL edges_d35_0 got=%b exp=011", cap0); end
      checks++; if (cap32 !== 32'hFEDC_BA98) begin errors++; $display("FAIL edges_d32 got=%h exp=fedcba98", cap32); end
      checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL edges_led got=%b exp=0", led_out); end
      checks++; if (n_err !== e) begin errors++; $display("FAIL edges_no_err got=%0d exp=%0d", n_err, e); end
      $display("edges 300/700/1200/1800: d35_1=%h d35_0=%b d32=%h", cap1, cap0, cap32);

      @(negedge clk);
      v = n_valid;
      e = n_err;
      line(1'b0, T_LEAD_M_US);
      line(1'b1, T_LEAD_S_US);
      line(1'b0, T_MARK_US);
      line(1'b1, 299);
      line(1'b0, T_MARK_US);
      line(1'b1, 2000);
      #200;
      checks++; if (n_err !== e + 1) begin errors++; $display("FAIL space299_err got=%0d exp=%0d", n_err, e + 1); end
      checks++; if (n_valid !== v) begin errors++; $display("FAIL space299_no_valid got=%0d exp=%0d", n_valid, v); end
      checks++; if (rx_data35_1 !== 32'h7878_7878) begin errors++; $display("FAIL space299_hold_d35_1 got=%h exp=78787878", rx_data35_1); end
      checks++; if (rx_data32 !== 32'hFEDC_BA98) begin errors++; $display("FAIL space299_hold_d32 got=%h exp=fedcba98", rx_data32); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL space299_busy got=%b exp=0", busy); end
      $display("space 299us: errs=%0d d35_1=%h busy=%b", n_err - e, rx_data35_1, busy);
   endtask

   task automatic test_leader_short();
      int v, e, rc;
      @(negedge clk);
      v = n_valid;
      e = n_err;
      line(1'b0, 7000);
      line(1'b1, T_LEAD_S_US);
      #200;
      checks++; if (n_err !== e + 1) begin errors++; $display("FAIL lead7000_err got=%0d exp=%0d", n_err, e + 1); end
      checks++; if (n_valid !== v) begin errors++; $display("FAIL lead7000_no_valid got=%0d exp=%0d", n_valid, v); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lead7000_busy got=%b exp=0", busy); end
      $display("leader 7000us: errs=%0d busy=%b", n_err - e, busy);
      @(negedge clk);
      send_frame(NOM35, NOM32, 1'b1, T_SPACE0_US, T_SPACE0_US, T_SPACE1_US, T_SPACE1_US, rc);
      #200;
      checks++; if (n_valid !== v + 1) begin errors++; $display("FAIL pad1_valid_count got=%0d exp=%0d", n_valid, v + 1); end
      checks++; if (cap1 !== 32'hB4B4_B4B4) begin errors++; $display("FAIL pad1_d35_1 got=%h exp=b4b4b4b4", cap1); end
      checks++; if (cap0 !== 3'b101) begin errors++; $display("FAIL pad1_d35_0 got=%b exp=101", cap0); end
      checks++; if (cap32 !== 32'h1234_5678) begin errors++; $display("FAIL pad1_d32 got=%h exp=12345678", cap32); end
      checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL pad1_led got=%b exp=1", led_out); end
      checks++; if (n_err !== e + 1) begin errors++; $display("FAIL pad1_no_err got=%0d exp=%0d", n_err, e + 1); end
      $display("recovery frame pad=1: d35_1=%h d35_0=%b d32=%h led=%b", cap1, cap0, cap32, led_out);
   endtask

   task automatic test_timeout();
      int v, e, fc;
      @(negedge clk);
      v = n_valid;
      e = n_err;
      line(1'b0, T_LEAD_M_US);
      line(1'b1, T_LEAD_S_US);
      send_bits(NOM35, 35, T_SPACE0_US, T_SPACE0_US, T_SPACE1_US, T_SPACE1_US);
      line(1'b0, T_MARK_US);
      line(1'b1, T_CONN_S_US);
      send_bits(35'(NOM32 >> 22), 10, T_SPACE0_US, T_SPACE0_US, T_SPACE1_US, T_SPACE1_US);
      #200;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before got=%b exp=1", busy); end
      @(negedge clk);
      fc = cyc;
      line(1'b0, 30000);
      line(1'b1, 2000);
      #200;
      checks++; if (n_err !== e + 1) begin errors++; $display("FAIL timeout_err got=%0d exp=%0d", n_err, e + 1); end
      checks++; if (err_cyc - fc !== 25004) begin errors++; $display("FAIL timeout_delay got=%0d exp=25004", err_cyc - fc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
      checks++; if (n_valid !== v) begin errors++; $display("FAIL timeout_no_valid got=%0d exp=%0d", n_valid, v); end
      checks++; if (rx_data32 !== 32'h1234_5678) begin errors++; $display("FAIL timeout_hold_d32 got=%h exp=12345678", rx_data32); end
      $display("timeout at d32 bit 10: err after %0d clk busy=%b", err_cyc - fc, busy);
   endtask

   task automatic test_connect_short();
      int v, e;
      @(negedge clk);
      v = n_valid;
      e = n_err;
      line(1'b0, T_LEAD_M_US);
      line(1'b1, T_LEAD_S_US);
      send_bits(NOM35, 35, T_SPACE0_US, T_SPACE0_US, T_SPACE1_US, T_SPACE1_US);
      line(1'b0, T_MARK_US);
      line(1'b1, 15000);
      line(1'b0, T_MARK_US);
      line(1'b1, 2000);
      #200;
      checks++; if (n_err !== e + 1) begin errors++; $display("FAIL conn15000_err got=%0d exp=%0d", n_err, e + 1); end
      checks++; if (n_valid !== v) begin errors++; $display("FAIL conn15000_no_valid got=%0d exp=%0d", n_valid, v); end
      checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL conn15000_led got=%b exp=1", led_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conn15000_busy got=%b exp=0", busy); end
      $display("connect space 15000us: errs=%0d busy=%b", n_err - e, busy);
   endtask

   task automatic test_reset_mid_frame();
      int v, e, rc;
      @(negedge clk);
      v = n_valid;
      e = n_err;
      line(1'b0, T_LEAD_M_US);
      line(1'b1, T_LEAD_S_US);
      send_bits(NOM35 >> 15, 20, T_SPACE0_US, T_SPACE0_US, T_SPACE1_US, T_SPACE1_US);
      line(1'b0, T_MARK_US);
      line(1'b1, 200);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      line(1'b1, 1000);
      #200;
      checks++; if (rx_data35_1 !== 32'h0) begin errors++; $display("FAIL midrst_d35_1 got=%h exp=0", rx_data35_1); end
      checks++; if (rx_data35_0 !== 3'h0) begin errors++; $display("FAIL midrst_d35_0 got=%h exp=0", rx_data35_0); end
      checks++; if (rx_data32 !== 32'h0) begin errors++; $display("FAIL midrst_d32 got=%h exp=0", rx_data32); end
      checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL midrst_led got=%b exp=0", led_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (n_err !== e) begin errors++; $display("FAIL midrst_no_err got=%0d exp=%0d", n_err, e); end
      $display("reset at d35 bit 20: d35_1=%h d32=%h led=%b busy=%b", rx_data35_1, rx_data32, led_out, busy);
      @(negedge clk);
      send_frame(NOM35, NOM32, 1'b0, T_SPACE0_US, T_SPACE0_US, T_SPACE1_US, T_SPACE1_US, rc);
      #200;
      checks++; if (n_valid !== v + 1) begin errors++; $display("FAIL postrst_valid_count got=%0d exp=%0d", n_valid, v + 1); end
      checks++; if (cap1 !== 32'hB4B4_B4B4) begin errors++; $display("FAIL postrst_d35_1 got=%h exp=b4b4b4b4", cap1); end
      checks++; if (cap32 !== 32'h1234_5678) begin errors++; $display("FAIL postrst_d32 got=%h exp=12345678", cap32); end
      checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL postrst_led got=%b exp=1", led_out); end
      $display("post-reset frame: d35_1=%h d32=%h led=%b", cap1, cap32, led_out);
   endtask

   initial begin
      #1_500_000_000;
      $display("FAIL watchdog simulation did not complete errors=%0d checks=%0d", errors, checks);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_nominal();
      test_window_edges();
      test_leader_short();
      test_timeout();
      test_connect_short();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
